// File: rtl/mod_addsub.sv
// Sequential modular adder/subtractor: (A +/- B) mod M.
// Two passes through one shared 514-bit adder: raw op, then correction.

module mpadder #(
    parameter int W = 514
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         subtract,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic [W:0]   result
);

    logic [W-1:0] a_reg;
    logic [W-1:0] b_reg;
    logic         sub_reg;
    logic [W:0]   sum;

    // Capture operands; B is inverted for subtraction (carry-in adds the 1)
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            sub_reg <= 1'b0;
        end else if (start) begin
            a_reg   <= in_a;
            b_reg   <= subtract ? ~in_b : in_b;
            sub_reg <= subtract;
        end
    end

    // Top bit flags a negative difference (no carry out on subtract)
    always_comb begin
        sum    = {1'b0, a_reg} + {1'b0, b_reg} + {{W{1'b0}}, sub_reg};
        result = {sum[W] ^ sub_reg, sum[W-1:0]};
    end

endmodule

module mod_addsub #(
    parameter int N = 512
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         subtract,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic [N-1:0] modulus,
    output logic [N-1:0] result,
    output logic         done,
    output logic         busy
);

    localparam int AW = N + 2;

    typedef enum logic [2:0] {
        IDLE,
        P1,
        C1,
        P2,
        C2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [N-1:0] a_reg;
    logic [N-1:0] b_reg;
    logic [N-1:0] m_reg;
    logic         sub_reg;
    logic [N-1:0] s_reg;
    logic         neg_reg;

    logic          add_start;
    logic          add_sub;
    logic [AW-1:0] add_a;
    logic [AW-1:0] add_b;
    logic [AW:0]   add_res;

    logic          accept;
    logic [N-1:0]  pick;

    assign accept = (state == IDLE) && start;
    assign busy   = (state != IDLE);

    mpadder #(
        .W(AW)
    ) u_add (
        .clk      (clk),
        .rst      (rst),
        .start    (add_start),
        .subtract (add_sub),
        .in_a     (add_a),
        .in_b     (add_b),
        .result   (add_res)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and adder drive for each pass
    always_comb begin
        state_nxt = state;
        add_start = 1'b0;
        add_sub   = 1'b0;
        add_a     = '0;
        add_b     = '0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = P1;
                end
            end
            P1: begin
                add_start = 1'b1;
                add_a     = {2'b00, a_reg};
                add_b     = {2'b00, b_reg};
                add_sub   = sub_reg;
                state_nxt = C1;
            end
            C1: begin
                add_start = 1'b1;
                add_a     = add_res[AW-1:0];
                add_b     = {2'b00, m_reg};
                add_sub   = ~sub_reg;
                state_nxt = P2;
            end
            P2: begin
                state_nxt = C2;
            end
            C2: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Pick the raw or corrected value for the final result
    always_comb begin
        pick = s_reg;
        if (sub_reg) begin
            if (neg_reg) begin
                pick = add_res[N-1:0];
            end
        end else if (!add_res[AW]) begin
            pick = add_res[N-1:0];
        end
    end

    // Operand latch, first-pass capture, result and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            m_reg   <= '0;
            sub_reg <= 1'b0;
            s_reg   <= '0;
            neg_reg <= 1'b0;
            result  <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                a_reg   <= in_a;
                b_reg   <= in_b;
                m_reg   <= modulus;
                sub_reg <= subtract;
            end
            if (state == C1) begin
                s_reg   <= add_res[N-1:0];
                neg_reg <= add_res[AW];
            end
            if (state == C2) begin
                result <= pick;
                done   <= 1'b1;
            end
        end
    end

endmodule

// File: doc/mod_addsub.md
# mod_addsub

Sequential modular adder/subtractor for the 512-bit datapath. It computes (A ± B) mod M for operands already reduced below M. It sits directly downstream of the 514-bit multi-precision adder `mpadder`, instantiates one copy of it, and drives it twice: a raw add/subtract pass, then a correction pass against the modulus. The Montgomery/exponentiation control uses it for final reductions and modular differences.

## Interface
Parameters:
- N, 512, operand and modulus width; the internal adder is N+2 = 514 bits wide.

Ports:
- clk  input  1  clock
- rst  input  1  reset: synchronous, active-high
- start  input  1  one-cycle request; sampled only in IDLE
- subtract  input  1  0: A+B mod M; 1: A−B mod M
- in_a  input  N  operand A, required < M
- in_b  input  N  operand B, required < M
- modulus  input  N  modulus M, odd, nonzero
- result  output  N  reduced result; held until the next accepted start
- done  output  1  one-cycle pulse when result is valid
- busy  output  1  high from the cycle after an accepted start until done

## Operation
- Internal adder contract:
  - On a clk edge with its start=1, `mpadder` registers A and B, or ~B when subtract=1.
  - From the next cycle its 515-bit result is combinational: the low 514 bits are the sum or difference.
  - Bit 514 = carry XOR subtract, so 1 means a negative difference.
  - Operands are zero-extended from N to 514 bits.
- On accepted start, latch in_a, in_b, modulus and subtract into internal registers. Later input changes are ignored.
- States: IDLE → P1 → C1 → P2 → C2 → IDLE.
  - IDLE: busy=0. start=1 → P1.
  - P1: drive the adder with start=1, A=a_reg, B=b_reg, subtract=sub_reg.
  - C1: capture s = adder result[513:0] and neg = result[514]. Drive the adder with start=1 and A=s.
    - Add: B=M, subtract=1, giving s−M.
    - Subtract: B=M, subtract=0, giving s+M.
  - P2: wait cycle; the adder output is valid.
  - C2: select and register result, pulse done, go to IDLE.
    - Add: if adder result[514]=1 (s<M), result=s[N−1:0]; else result=adder[N−1:0].
    - Subtract: if neg=1, result=adder[N−1:0] (wraps mod 2^514; the low N bits are exact); else result=s[N−1:0].
- Arithmetic: A+B < 2M < 2^(N+1), so it fits in 514 bits without overflow. For A−B, the borrow is indicated solely by bit 514.
- start while busy: ignored. The in-flight operation completes unaffected, and no request is queued.
- Undefined (no checking): inputs ≥ M, or M = 0.

## Timing
- Reset values: result=0, done=0, busy=0, state=IDLE, and all internal operand registers 0.
- rst asserted mid-operation: return to IDLE on that edge. No done pulse; result=0.
- Latency: start is sampled at edge k, and done=1 and result are valid during the cycle after edge k+4. This is fixed and data-independent.
- done lasts exactly one cycle. busy is high for exactly 4 cycles per operation.
- Throughput: a new start is accepted in the cycle done is high (the state is IDLE then). The minimum issue interval is 5 cycles.
- result changes only on the edge that asserts done, or on reset.

## Test plan
- M=11, A=5, B=7, subtract=0 → result=1, done exactly 5 cycles after start is applied; busy high 4 cycles.
- M=11, A=4, B=7, add → result=0 (sum equals M exactly). M=11, A=3, B=8, subtract → result=6 (borrow path). A=B=9, subtract → result=0.
- Wide carry:
  - M=2^512−1, A=B=2^512−2, add → result=2^512−3; the 513-bit intermediate must be handled.
  - Same M, A=0, B=1, subtract → result=2^512−2.
- Issue a second start with different operands at each cycle while busy → ignored. The first result is unchanged, with a single done pulse.
- Assert rst for 1 cycle in P2 → done never pulses, result=0, busy=0. The next start then completes normally with a correct result.
- Back-to-back: issue start in each done cycle for 100 random (A, B < M, op) triples against a reference model → all match, interval 5 cycles.
